// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: opcode decode plus an FSM for blocking IN,
// counted DELAY, HALT/resume and interrupt entry/RETI. Optional macro: CU_DELAY_PRESCALE_EN.
module control_sequencer #(
    parameter int OPCODE_W = 6,
    parameter int DELAY_W  = 16,
    parameter int PRESCALE = 50000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                flagJB,
    input  logic                interruption,
    input  logic                resume,
    input  logic                in_valid,
    input  logic [DELAY_W-1:0]  delay_val,
    output logic                flagDM,
    output logic                flagJR,
    output logic                flagLSR,
    output logic                flagRF,
    output logic                flagOUT,
    output logic                LED,
    output logic [1:0]          flagPC,
    output logic [1:0]          flagBQ,
    output logic [2:0]          flagMuxRF,
    output logic                in_ack,
    output logic                irq_take,
    output logic                reti,
    output logic                in_isr,
    output logic                illegal_op
);

    typedef enum logic [1:0] {S_RUN, S_IN_WAIT, S_DELAY, S_HALT} state_t;

    state_t             state, state_nx;
    logic [DELAY_W-1:0] cnt, cnt_nx;
    logic               isr_q, isr_nx;
    logic               tick;
    logic               irq_ok;

`ifdef CU_DELAY_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    logic [PW-1:0] pre;

    // Held at zero outside DELAY so every DELAY entry starts a fresh period.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                          pre <= '0;
        else if (state != S_DELAY)          pre <= '0;
        else if (pre == PW'(PRESCALE - 1))  pre <= '0;
        else                                pre <= pre + PW'(1);
    end
    assign tick = (pre == PW'(PRESCALE - 1));
`else
    assign tick = 1'b1;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_RUN;
            cnt   <= '0;
            isr_q <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            isr_q <= isr_nx;
        end
    end

    assign irq_ok = interruption && !isr_q;
    assign in_isr = isr_q;

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        isr_nx     = isr_q;
        flagDM     = 1'b0;
        flagJR     = 1'b0;
        flagLSR    = 1'b0;
        flagRF     = 1'b0;
        flagOUT    = 1'b0;
        LED        = 1'b0;
        flagPC     = 2'd0;
        flagBQ     = 2'd0;
        flagMuxRF  = 3'd0;
        in_ack     = 1'b0;
        irq_take   = 1'b0;
        reti       = 1'b0;
        illegal_op = 1'b0;
        if (!reset) begin
            unique case (state)
                S_RUN: begin
                    if (irq_ok) begin
                        irq_take = 1'b1;
                        flagPC   = 2'd3;
                        isr_nx   = 1'b1;
                    end else if (opcode > OPCODE_W'(15)) begin
                        illegal_op = 1'b1;
                    end else begin
                        flagPC = 2'd1;
                        case (opcode[3:0])
                            4'd0:  begin flagRF = 1'b1; flagMuxRF = 3'd1; end
                            4'd1:  begin flagRF = 1'b1; flagMuxRF = 3'd2; end
                            4'd2:  begin flagRF = 1'b1; flagMuxRF = 3'd4; end
                            4'd3:  begin flagRF = 1'b1; flagMuxRF = 3'd2; flagLSR = 1'b1; end
                            4'd4:  flagDM = 1'b1;
                            4'd5:  begin flagDM = 1'b1; flagLSR = 1'b1; end
                            4'd6:  begin flagBQ = 2'd1; flagPC = flagJB ? 2'd2 : 2'd1; end
                            4'd7:  begin flagBQ = 2'd2; flagPC = flagJB ? 2'd2 : 2'd1; end
                            4'd8:  flagPC = 2'd2;
                            4'd9:  begin flagJR = 1'b1; flagPC = 2'd2; end
                            4'd10: ;
                            4'd11: begin
                                flagOUT  = 1'b1;
                                flagPC   = 2'd0;
                                state_nx = S_HALT;
                            end
                            4'd12: begin
                                LED = 1'b1;
                                if (in_valid) begin
                                    flagRF    = 1'b1;
                                    flagMuxRF = 3'd3;
                                    flagOUT   = 1'b1;
                                    in_ack    = 1'b1;
                                end else begin
                                    flagPC   = 2'd0;
                                    state_nx = S_IN_WAIT;
                                end
                            end
                            4'd13: flagOUT = 1'b1;
                            4'd14: begin
                                if (delay_val <= DELAY_W'(1)) begin
                                    flagOUT = 1'b1;
                                end else begin
                                    flagPC   = 2'd0;
                                    cnt_nx   = delay_val - DELAY_W'(1);
                                    state_nx = S_DELAY;
                                end
                            end
                            default: begin
                                // RETI outside an ISR degrades to NOP
                                if (isr_q) begin
                                    reti   = 1'b1;
                                    flagPC = 2'd2;
                                    isr_nx = 1'b0;
                                end
                            end
                        endcase
                    end
                end
                S_IN_WAIT: begin
                    LED = 1'b1;
                    if (in_valid) begin
                        flagRF    = 1'b1;
                        flagMuxRF = 3'd3;
                        flagOUT   = 1'b1;
                        flagPC    = 2'd1;
                        in_ack    = 1'b1;
                        state_nx  = S_RUN;
                    end
                end
                S_DELAY: begin
                    flagOUT = 1'b1;
                    if (tick) begin
                        cnt_nx = cnt - DELAY_W'(1);
                        if (cnt == DELAY_W'(1)) begin
                            flagPC   = 2'd1;
                            state_nx = S_RUN;
                        end
                    end
                end
                default: begin
                    // HALT: a pending interrupt wins over resume
                    if (irq_ok) begin
                        irq_take = 1'b1;
                        flagPC   = 2'd3;
                        isr_nx   = 1'b1;
                        state_nx = S_RUN;
                    end else begin
                        flagOUT = 1'b1;
                        if (resume) begin
                            flagPC   = 2'd1;
                            state_nx = S_RUN;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: driver pushes reference-model
// expectations, a negedge monitor pops and compares the full output set.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        flagJB, interruption, resume, in_valid;
    logic [15:0] delay_val;
    logic        flagDM, flagJR, flagLSR, flagRF, flagOUT, LED;
    logic [1:0]  flagPC, flagBQ;
    logic [2:0]  flagMuxRF;
    logic        in_ack, irq_take, reti, in_isr, illegal_op;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clock(clk), .reset(reset), .opcode(opcode), .flagJB(flagJB),
        .interruption(interruption), .resume(resume), .in_valid(in_valid),
        .delay_val(delay_val), .flagDM(flagDM), .flagJR(flagJR), .flagLSR(flagLSR),
        .flagRF(flagRF), .flagOUT(flagOUT), .LED(LED), .flagPC(flagPC),
        .flagBQ(flagBQ), .flagMuxRF(flagMuxRF), .in_ack(in_ack),
        .irq_take(irq_take), .reti(reti), .in_isr(in_isr), .illegal_op(illegal_op)
    );

    typedef struct packed {
        logic dm, jr, lsr, rf, out, led;
        logic [1:0] pc, bq;
        logic [2:0] mux;
        logic ack, irq, rti, isr, ill;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0, n_err = 0, cyc_no = 0;

    // Reference model: what the sequencer is "doing" in plain terms.
    bit waiting, halted, isr;
    int delay_left;

    function automatic exp_t decode(int op, bit jb);
        exp_t e = '0;
        e.pc = 2'd1;
        case (op)
            0:  begin e.rf = 1; e.mux = 3'd1; end
            1:  begin e.rf = 1; e.mux = 3'd2; end
            2:  begin e.rf = 1; e.mux = 3'd4; end
            3:  begin e.rf = 1; e.mux = 3'd2; e.lsr = 1; end
            4:  e.dm = 1;
            5:  begin e.dm = 1; e.lsr = 1; end
            6:  begin e.bq = 2'd1; e.pc = jb ? 2'd2 : 2'd1; end
            7:  begin e.bq = 2'd2; e.pc = jb ? 2'd2 : 2'd1; end
            8:  e.pc = 2'd2;
            9:  begin e.jr = 1; e.pc = 2'd2; end
            13: e.out = 1;
            default: ;
        endcase
        return e;
    endfunction

    task automatic cyc(input int op, input bit jb, input bit irq, input bit res,
                       input bit iv, input int dv, input bit rst);
        exp_t e = '0;
        bit   irq_ok;
        @(posedge clk);
        #1;
        reset = rst; opcode = 6'(op); flagJB = jb; interruption = irq;
        resume = res; in_valid = iv; delay_val = 16'(dv);
        cyc_no++;
        if (rst) begin
            waiting = 0; halted = 0; isr = 0; delay_left = 0;
            q.push_back(e);
            return;
        end
        e.isr  = isr;
        irq_ok = irq && !isr;
        if (waiting) begin
            e.led = 1;
            if (iv) begin
                e.rf = 1; e.mux = 3'd3; e.out = 1; e.pc = 2'd1; e.ack = 1;
                waiting = 0;
            end
        end else if (delay_left > 0) begin
            e.out = 1;
            if (delay_left == 1) e.pc = 2'd1;
            delay_left--;
        end else if (halted && irq_ok) begin
            e.irq = 1; e.pc = 2'd3; isr = 1; halted = 0;
        end else if (halted) begin
            e.out = 1;
            if (res) begin e.pc = 2'd1; halted = 0; end
        end else if (irq_ok) begin
            e.irq = 1; e.pc = 2'd3; isr = 1;
        end else if (op > 15) begin
            e.ill = 1;
        end else if (op == 11) begin
            e.out = 1; halted = 1;
        end else if (op == 12) begin
            e.led = 1;
            if (iv) begin
                e.rf = 1; e.mux = 3'd3; e.out = 1; e.pc = 2'd1; e.ack = 1;
            end else waiting = 1;
        end else if (op == 14) begin
            if (dv <= 1) begin e.out = 1; e.pc = 2'd1; end
            else delay_left = dv - 1;
        end else if (op == 15) begin
            e.pc = 2'd1;
            if (isr) begin e.rti = 1; e.pc = 2'd2; isr = 0; end
        end else begin
            e = decode(op, jb);
            e.isr = isr;
        end
        q.push_back(e);
    endtask

    // Asynchronous reset asserted between edges with no clock edge in between.
    task automatic async_reset_now();
        exp_t e = '0;
        #2;
        reset = 1'b1;
        waiting = 0; halted = 0; isr = 0; delay_left = 0;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t exp_v, got;
            exp_v = q.pop_front();
            got = '{flagDM, flagJR, flagLSR, flagRF, flagOUT, LED, flagPC, flagBQ,
                    flagMuxRF, in_ack, irq_take, reti, in_isr, illegal_op};
            n_cmp++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL outputs t=%0t cyc=%0d got=%b required=%b", $time, cyc_no, got, exp_v);
            end
        end
    end

    initial begin
        reset = 1; opcode = 0; flagJB = 0; interruption = 0; resume = 0;
        in_valid = 0; delay_val = 0;
        waiting = 0; halted = 0; isr = 0; delay_left = 0;
        // reset state
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(12, 1, 1, 1, 1, 0, 1);
        cyc(10, 0, 0, 0, 0, 0, 0);
        // DELAY 10, reach counter 7, then async reset mid-cycle
        cyc(14, 0, 0, 0, 0, 10, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        cyc_no++;
        async_reset_now();
        cyc(10, 0, 0, 0, 0, 0, 0);
        // IN blocking
        for (int i = 0; i < 5; i++) cyc(12, 0, 0, 0, 0, 0, 0);
        cyc(12, 0, 0, 0, 1, 0, 0);
        // DELAY 4 and 0
        cyc(14, 0, 0, 0, 0, 4, 0);
        for (int i = 0; i < 3; i++) cyc(10, 0, 0, 0, 0, 0, 0);
        cyc(14, 0, 0, 0, 0, 0, 0);
        cyc(14, 0, 0, 0, 0, 1, 0);
        // interrupt entry, masking, RETI
        cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(15, 0, 0, 0, 0, 0, 0);
        cyc(15, 0, 0, 0, 0, 0, 0);
        // HALT, interrupt beats resume, then RETI
        cyc(11, 0, 0, 0, 0, 0, 0);
        cyc(10, 0, 0, 0, 0, 0, 0);
        cyc(10, 0, 1, 1, 0, 0, 0);
        cyc(15, 0, 0, 0, 0, 0, 0);
        // branches, jump, illegal stall
        cyc(6, 1, 0, 0, 0, 0, 0);
        cyc(6, 0, 0, 0, 0, 0, 0);
        cyc(7, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(40, 0, 0, 0, 0, 0, 0);
        for (int op = 0; op < 16; op++) cyc(op, 0, 0, 1, 1, 2, 0);
        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            int op;
            op = ($urandom_range(0, 99) < 88) ? int'($urandom_range(0, 15))
                                              : int'($urandom_range(16, 63));
            cyc(op, 1'($urandom), ($urandom_range(0, 99) < 8),
                ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 40),
                int'($urandom_range(0, 6)), ($urandom_range(0, 199) == 0));
        end
        repeat (3) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain left=%0d required=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
